// File: rtl/pwm_capture_16bits.sv
// Input-capture unit: measures the period and the active time of an external PWM signal in clk
// cycles and publishes one result per rising edge, with saturation, timeout and enable handling.
module pwm_capture_16bits #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_onoff,
    input  logic             polarity,
    input  logic [WIDTH-1:0] timeout,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period_meas,
    output logic [WIDTH-1:0] high_meas,
    output logic             meas_valid,
    output logic             overflow,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        OFF,
        ARM,
        HIGH,
        LOW
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       high_cap;
    logic [WIDTH:0]         cnt_plus1;
    logic [WIDTH-1:0]       cnt_sat_inc;
    logic                   cnt_full;
    logic                   timed_out;

    assign s    = sync_ff[SYNC_STAGES-1] ^ polarity;
    assign rise = s & ~prev;
    assign fall = ~s & prev;

    // cnt+1 is kept one bit wider so the timeout compare still fires once cnt has saturated
    assign cnt_full    = (cnt == ALL_ONES);
    assign cnt_plus1   = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign cnt_sat_inc = cnt_full ? ALL_ONES : cnt_plus1[WIDTH-1:0];
    assign timed_out   = (timeout != '0) && (cnt_plus1 >= {1'b0, timeout});

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
            prev    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= OFF;
            cnt         <= '0;
            high_cap    <= '0;
            period_meas <= '0;
            high_meas   <= '0;
            meas_valid  <= 1'b0;
            overflow    <= 1'b0;
            no_signal   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!cap_onoff) begin
                state    <= OFF;
                cnt      <= '0;
                high_cap <= '0;
                overflow <= 1'b0;
                no_signal <= 1'b0;
            end else begin
                case (state)
                    OFF: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    // The first partial period after arming is never published
                    ARM: begin
                        cnt <= '0;
                        if (rise) begin
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (timed_out) begin
                            state     <= ARM;
                            cnt       <= '0;
                            no_signal <= 1'b1;
                        end else if (fall) begin
                            state    <= LOW;
                            high_cap <= cnt_sat_inc;
                            cnt      <= cnt_sat_inc;
                            if (cnt_full) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_sat_inc;
                        end
                    end
                    LOW: begin
                        if (timed_out) begin
                            state     <= ARM;
                            cnt       <= '0;
                            no_signal <= 1'b1;
                        end else if (rise) begin
                            state       <= HIGH;
                            period_meas <= cnt_sat_inc;
                            high_meas   <= high_cap;
                            meas_valid  <= 1'b1;
                            no_signal   <= 1'b0;
                            cnt         <= '0;
                            if (cnt_full) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_sat_inc;
                        end
                    end
                    default: begin
                        state <= OFF;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Bench for pwm_capture_16bits: timestamp-based reference model checked every cycle, plus a
// vector table of waveforms with known results and hand-written enable/timeout/reset sequences.
module tb_pwm_capture_16bits;

    localparam int W   = 10;
    localparam int SS  = 2;
    localparam int SAT = (1 << W) - 1;
    localparam int NV  = 7;

    logic         clk;
    logic         reset;
    logic         cap_onoff;
    logic         polarity;
    logic [W-1:0] timeout;
    logic         pwm_in;
    logic [W-1:0] period_meas;
    logic [W-1:0] high_meas;
    logic         meas_valid;
    logic         overflow;
    logic         no_signal;

    int checks = 0;
    int passes = 0;
    int valid_count = 0;
    int base;

    typedef struct {
        int   period;
        int   high;
        bit   pol;
        int   exp_period;
        int   exp_high;
        bit   exp_ovf;
    } vec_t;

    vec_t vecs[NV];

    pwm_capture_16bits #(
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cap_onoff   (cap_onoff),
        .polarity    (polarity),
        .timeout     (timeout),
        .pwm_in      (pwm_in),
        .period_meas (period_meas),
        .high_meas   (high_meas),
        .meas_valid  (meas_valid),
        .overflow    (overflow),
        .no_signal   (no_signal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the pin is delayed through the synchronizer, then each result is the
    // distance in clock edges between observed edges of the (polarity-adjusted) signal.
    bit     m_q[$];
    bit     m_prev = 1'b0;
    bit     m_off = 1'b1;
    bit     m_meas = 1'b0;
    bit     m_in_high = 1'b0;
    bit     m_s, m_rise, m_fall;
    longint tick = 0;
    longint m_last_rise = 0;
    longint m_elapsed;
    int     m_high_cap = 0;
    int     e_period = 0;
    int     e_high = 0;
    bit     e_valid = 1'b0;
    bit     e_ovf = 1'b0;
    bit     e_nosig = 1'b0;

    function automatic int sat(input longint v);
        return (v > SAT) ? SAT : int'(v);
    endfunction

    always @(posedge clk) begin
        tick++;
        m_s    = (m_q.size() == SS) ? (m_q[SS-1] ^ polarity) : 1'b0;
        m_rise = m_s && !m_prev;
        m_fall = !m_s && m_prev;
        e_valid = 1'b0;
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
            m_prev = 1'b0;
            m_off = 1'b1;
            m_meas = 1'b0;
            m_high_cap = 0;
            e_period = 0;
            e_high = 0;
            e_ovf = 1'b0;
            e_nosig = 1'b0;
        end else begin
            m_prev = m_s;
            m_q.push_front(pwm_in);
            void'(m_q.pop_back());
            if (!cap_onoff) begin
                m_off = 1'b1;
                m_meas = 1'b0;
                m_high_cap = 0;
                e_ovf = 1'b0;
                e_nosig = 1'b0;
            end else if (m_off) begin
                m_off = 1'b0;
            end else if (!m_meas) begin
                if (m_rise) begin
                    m_meas = 1'b1;
                    m_in_high = 1'b1;
                    m_last_rise = tick;
                end
            end else begin
                m_elapsed = tick - m_last_rise;
                if (timeout != 0 && m_elapsed >= longint'(timeout)) begin
                    m_meas = 1'b0;
                    e_nosig = 1'b1;
                end else if (m_in_high && m_fall) begin
                    m_high_cap = sat(m_elapsed);
                    if (m_elapsed > SAT) e_ovf = 1'b1;
                    m_in_high = 1'b0;
                end else if (!m_in_high && m_rise) begin
                    e_period = sat(m_elapsed);
                    e_high = m_high_cap;
                    e_valid = 1'b1;
                    e_nosig = 1'b0;
                    if (m_elapsed > SAT) e_ovf = 1'b1;
                    m_last_rise = tick;
                    m_in_high = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cycle_outputs",
                    64'({period_meas, high_meas, meas_valid, overflow, no_signal}),
                    64'({W'(e_period), W'(e_high), e_valid, e_ovf, e_nosig}));
        if (meas_valid) valid_count++;
    end

    // Drives whole PWM periods starting at a falling clock edge, leaving pwm_in low afterwards
    task automatic applyStimulus(input int period, input int high, input int n_periods);
        for (int p = 0; p < n_periods; p++) begin
            pwm_in = 1'b1;
            repeat (high) @(negedge clk);
            pwm_in = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask

    task automatic restartCapture(input bit pol, input int tmo);
        cap_onoff = 1'b0;
        polarity  = pol;
        timeout   = W'(tmo);
        repeat (3) @(negedge clk);
        cap_onoff = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p, h;

        vecs[0] = '{period: 100,  high: 30,  pol: 1'b0, exp_period: 100, exp_high: 30,  exp_ovf: 1'b0};
        vecs[1] = '{period: 100,  high: 30,  pol: 1'b1, exp_period: 100, exp_high: 70,  exp_ovf: 1'b0};
        vecs[2] = '{period: 37,   high: 1,   pol: 1'b0, exp_period: 37,  exp_high: 1,   exp_ovf: 1'b0};
        vecs[3] = '{period: 1100, high: 100, pol: 1'b0, exp_period: SAT, exp_high: 100, exp_ovf: 1'b1};
        vecs[4] = '{period: SAT,  high: 20,  pol: 1'b0, exp_period: SAT, exp_high: 20,  exp_ovf: 1'b0};
        vecs[5] = '{period: 2,    high: 1,   pol: 1'b0, exp_period: 2,   exp_high: 1,   exp_ovf: 1'b0};
        vecs[6] = '{period: 150,  high: 149, pol: 1'b1, exp_period: 150, exp_high: 1,   exp_ovf: 1'b0};

        reset = 1'b1;
        cap_onoff = 1'b0;
        polarity = 1'b0;
        timeout = '0;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state",
                    64'({period_meas, high_meas, meas_valid, overflow, no_signal}), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            restartCapture(vecs[i].pol, 0);
            base = valid_count;
            applyStimulus(vecs[i].period, vecs[i].high, 3);
            repeat (6) @(negedge clk);
            checkOutput($sformatf("vec%0d_period", i), 64'(period_meas), 64'(vecs[i].exp_period));
            checkOutput($sformatf("vec%0d_high", i), 64'(high_meas), 64'(vecs[i].exp_high));
            checkOutput($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].exp_ovf));
            checkOutput($sformatf("vec%0d_valid_count", i), 64'(valid_count - base), 64'(2));
        end

        for (int r = 0; r < 20; r++) begin
            p = int'($urandom_range(2, 300));
            h = int'($urandom_range(1, p - 1));
            restartCapture(1'($urandom_range(0, 1)),
                           ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(5, 400)));
            applyStimulus(p, h, int'($urandom_range(2, 4)));
            repeat (5) @(negedge clk);
        end

        // Timeout: one pulse then silence, limit 50 cycles after the observed rise
        restartCapture(1'b0, 50);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("nosig_before_limit", 64'(no_signal), 64'(0));
        repeat (15) @(negedge clk);
        checkOutput("nosig_after_limit", 64'(no_signal), 64'(1));
        timeout = W'(200);
        base = valid_count;
        applyStimulus(100, 30, 2);
        repeat (5) @(negedge clk);
        checkOutput("nosig_cleared", 64'(no_signal), 64'(0));
        checkOutput("restart_valid_count", 64'(valid_count - base), 64'(1));
        checkOutput("restart_period", 64'(period_meas), 64'(100));

        // Capture switched off mid-HIGH after an overflow, then re-enabled
        restartCapture(1'b0, 0);
        applyStimulus(1100, 100, 2);
        repeat (5) @(negedge clk);
        checkOutput("ovf_set", 64'(overflow), 64'(1));
        pwm_in = 1'b1;
        repeat (15) @(negedge clk);
        cap_onoff = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("off_period_held", 64'(period_meas), 64'(SAT));
        checkOutput("off_high_held", 64'(high_meas), 64'(100));
        checkOutput("off_ovf_cleared", 64'(overflow), 64'(0));
        base = valid_count;
        cap_onoff = 1'b1;
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (70) @(negedge clk);
        applyStimulus(100, 30, 1);
        checkOutput("reenable_no_valid", 64'(valid_count - base), 64'(0));
        applyStimulus(100, 30, 1);
        repeat (5) @(negedge clk);
        checkOutput("reenable_valid", 64'(valid_count - base), 64'(1));
        checkOutput("reenable_high", 64'(high_meas), 64'(30));

        // Reset in the middle of the low phase
        applyStimulus(100, 30, 2);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_low",
                    64'({period_meas, high_meas, meas_valid, overflow, no_signal}), 64'(0));
        reset = 1'b0;
        base = valid_count;
        repeat (50) @(negedge clk);
        applyStimulus(100, 30, 1);
        checkOutput("post_reset_no_valid", 64'(valid_count - base), 64'(0));
        applyStimulus(100, 30, 1);
        repeat (5) @(negedge clk);
        checkOutput("post_reset_valid", 64'(valid_count - base), 64'(1));
        checkOutput("post_reset_period", 64'(period_meas), 64'(100));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
